layer1_pool_buf: RTL

LAYER1_POOL_BUF -- requirements
Module: layer1_pool_buf

---
 rtl/layer1_pool_buf_pkg.sv | 17 +
 rtl/layer1_pool_buf_if.sv | 25 ++
 rtl/layer1_pool_buf_sync_fifo.sv | 58 +++++
 rtl/layer1_pool_buf.sv | 116 +++++++++++
 4 files changed

// File: rtl/layer1_pool_buf_pkg.sv
// Shared constants for the layer-1 pooling buffer: default geometry, FSM encoding, index sizing helper.
package layer1_pool_buf_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_IMG_W  = 28;
    localparam int DEFAULT_IMG_H  = 28;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVEN = 2'd1;
    localparam logic [1:0] S_ODD  = 2'd2;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer1_pool_buf_if.sv
// Pixel-in / pooled-word-out bundle between a layer-1 producer, the pooling buffer and its consumer.
interface layer1_pool_buf_if
    import layer1_pool_buf_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              frame_start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              frame_done;
    logic              overflow;

    modport master (
        output frame_start, in_valid, in_data, out_ready,
        input  out_valid, out_data, frame_done, overflow
    );

    modport slave (
        input  frame_start, in_valid, in_data, out_ready,
        output out_valid, out_data, frame_done, overflow
    );
endinterface

// File: rtl/layer1_pool_buf_sync_fifo.sv
// Small synchronous FIFO with full/empty flags; FIFO_DEPTH must be a power of two, at least 2.
module sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = FIFO_DEPTH[PTR_W:0];

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              doPush, doPop;

    assign full_o     = (count_q == FULL_COUNT);
    assign empty_o    = (count_q == '0);
    assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

    // A push into a full FIFO is allowed only when a pop frees the head slot on the same edge.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_comb begin
        wr_d    = doPush ? wr_q + 1'b1 : wr_q;
        rd_d    = doPop ? rd_q + 1'b1 : rd_q;
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/layer1_pool_buf.sv
// 2x2 binary max-pool of a raster pixel stream: even rows are half-pooled into a line buffer,
// odd rows complete each window and push the pooled word into an output FIFO.
module layer1_pool_buf
    import layer1_pool_buf_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int IMG_W      = DEFAULT_IMG_W,
    parameter int IMG_H      = DEFAULT_IMG_H,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    layer1_pool_buf_if.slave  bus
);
    localparam int COL_W  = idx_w(IMG_W);
    localparam int ROW_W  = idx_w(IMG_H);
    localparam int HALF_W = idx_w(IMG_W / 2);

    logic [1:0]        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] hreg_q, hreg_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] line_buf_q [IMG_W/2];

    logic              acceptWord, colLast, rowLast;
    logic              lineWrite, pushWord, popWord;
    logic              fifoFull, fifoEmpty;
    logic [HALF_W-1:0] pairIdx;
    logic [DATA_W-1:0] pushData;

    // frame_start takes priority over a word arriving in the same cycle.
    assign acceptWord = bus.in_valid && !bus.frame_start && (state_q != S_IDLE);
    assign colLast    = (col_q == COL_W'(IMG_W - 1));
    assign rowLast    = (row_q == ROW_W'(IMG_H - 1));
    assign pairIdx    = HALF_W'(col_q >> 1);
    assign pushData   = line_buf_q[pairIdx] | hreg_q | bus.in_data;
    assign popWord    = bus.out_ready && !fifoEmpty;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        hreg_d       = hreg_q;
        frame_done_d = 1'b0;
        lineWrite    = 1'b0;
        pushWord     = 1'b0;
        if (bus.frame_start) begin
            state_d = S_EVEN;
            col_d   = '0;
            row_d   = '0;
            hreg_d  = '0;
        end else if (acceptWord) begin
            if (!col_q[0])              hreg_d    = bus.in_data;
            else if (state_q == S_EVEN) lineWrite = 1'b1;
            else                        pushWord  = 1'b1;

            if (colLast) begin
                col_d   = '0;
                row_d   = row_q + 1'b1;
                state_d = (state_q == S_EVEN) ? S_ODD : S_EVEN;
                if (rowLast) begin
                    row_d        = '0;
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        overflow_d = overflow_q | (pushWord && fifoFull && !popWord);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            hreg_q       <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hreg_q       <= hreg_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // No reset needed: each entry is written in an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lineWrite) line_buf_q[pairIdx] <= hreg_q | bus.in_data;
    end

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pushWord),
        .push_data_i (pushData),
        .pop_i       (popWord),
        .pop_data_o  (bus.out_data),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty)
    );

    assign bus.out_valid  = !fifoEmpty;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;

endmodule
